// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Brief    : Two-requester round-robin arbiter driving the 2:1 mux select.
//            ARB_PREEMPT_EN enables contention preemption after HOLD_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic s,
  output logic busy
);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("mux_sel_arbiter: HOLD_CYCLES must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_max  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
`ifdef ARB_PREEMPT_EN
  localparam logic c_preempt = 1'b1;
`else
  localparam logic c_preempt = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             w_last_next;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_s;
  logic             w_s_next;
  logic             w_hold_done;
  logic             w_entry;

  assign w_hold_done = c_preempt & (r_cnt == c_hold_last);
  assign w_entry     = (w_next != r_state) && (w_next != IDLE);

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    w_s_next    = r_s;
    case (r_state)
      IDLE: begin
        // Tie goes to whichever requester was not granted most recently
        if (req0 && req1) w_next = r_last ? G0 : G1;
        else if (req0)    w_next = G0;
        else if (req1)    w_next = G1;
      end
      G0: begin
        if (!req0)                   w_next = req1 ? G1 : IDLE;
        else if (req1 && w_hold_done) w_next = G1;
      end
      G1: begin
        if (!req1)                   w_next = req0 ? G0 : IDLE;
        else if (req0 && w_hold_done) w_next = G0;
      end
      default: w_next = IDLE;
    endcase
    if (w_next == G0) begin
      w_last_next = 1'b0;
      w_s_next    = 1'b0;
    end else if (w_next == G1) begin
      w_last_next = 1'b1;
      w_s_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
      r_gnt0  <= (w_next == G0);
      r_gnt1  <= (w_next == G1);
      r_s     <= w_s_next;
    end
  end

`ifdef ARB_PREEMPT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_entry) begin
      r_cnt <= '0;
    end else if (r_state != IDLE && r_cnt != c_hold_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  // Owner keeps the grant until release, so tenure is never tracked
  assign r_cnt = (w_entry && c_hold_max != '0) ? '0 : '0;
`endif

  assign gnt0 = r_gnt0;
  assign gnt1 = r_gnt1;
  assign s    = r_s;
  assign busy = r_gnt0 | r_gnt1;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// Testbench for mux_sel_arbiter: directed vectors checked against a
// grant-ownership model every cycle, plus literal expectations.
module tb_mux_sel_arbiter;

  localparam int HOLD = 4;
`ifdef ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic s;
  logic busy;

  logic [7:0] i0 = 8'hA5;
  logic [7:0] i1 = 8'h3C;
  logic [7:0] mout;
  assign mout = s ? i1 : i0;

  int n_vec = 0;
  int n_err = 0;

  mux_sel_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk  (clk),
    .reset(reset),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .s    (s),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Model: who owns the mux, for how many cycles, and who won last
  int m_owner;
  int m_tenure;
  int m_last;
  int m_win;
  bit m_s;
  bit m_r[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner  = -1;
      m_tenure = 0;
      m_last   = 1;
      m_s      = 1'b0;
    end else begin
      m_r[0] = req0;
      m_r[1] = req1;
      if (m_owner < 0) begin
        if (m_r[0] && m_r[1]) m_win = 1 - m_last;
        else if (m_r[0])      m_win = 0;
        else if (m_r[1])      m_win = 1;
        else                  m_win = -1;
      end else if (!m_r[m_owner]) begin
        m_win = m_r[1-m_owner] ? 1 - m_owner : -1;
      end else if (m_r[1-m_owner] && PRE && m_tenure >= HOLD) begin
        m_win = 1 - m_owner;
      end else begin
        m_win = m_owner;
      end
      if (m_win >= 0 && m_win != m_owner) begin
        m_tenure = 1;
        m_last   = m_win;
        m_s      = (m_win == 1);
      end else if (m_win >= 0) begin
        m_tenure = m_tenure + 1;
      end
      m_owner = m_win;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("mdl_gnt0", 8'(gnt0), 8'(m_owner == 0));
    check("mdl_gnt1", 8'(gnt1), 8'(m_owner == 1));
    check("mdl_s",    8'(s),    8'(m_s));
    check("mdl_busy", 8'(busy), 8'(m_owner >= 0));
    check("inv_excl", 8'(gnt0 & gnt1), 8'(0));
    if (busy) check("inv_s_gnt1", 8'(s), 8'(gnt1));
  end

  task automatic lit(input string name, input logic g0, input logic g1, input logic ss);
    check({name, "_gnt0"}, 8'(gnt0), 8'(g0));
    check({name, "_gnt1"}, 8'(gnt1), 8'(g1));
    check({name, "_s"},    8'(s),    8'(ss));
    check({name, "_busy"}, 8'(busy), 8'(g0 | g1));
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    #12;
    lit("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Single requester holds for 10 cycles, then idle keeps s
    req1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      edge1();
      lit("single", 1'b0, 1'b1, 1'b1);
    end
    req1 = 1'b0;
    edge1();
    lit("single_idle", 1'b0, 1'b0, 1'b1);

    // Early release transfers directly with no idle cycle
    req0 = 1'b1;
    edge1();
    lit("early_g0", 1'b1, 1'b0, 1'b0);
    req1 = 1'b1;
    edge1();
    lit("early_hold", 1'b1, 1'b0, 1'b0);
    req0 = 1'b0;
    edge1();
    lit("early_direct", 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    edge1();
    lit("early_idle", 1'b0, 1'b0, 1'b1);

    // Sustained contention from IDLE with last=1
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      int own;
      edge1();
      own = PRE ? ((k / HOLD) % 2) : 0;
      lit("contend", own == 0, own == 1, own == 1);
    end
    req0 = 1'b0;
    edge1();
    lit("contend_drop", 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    edge1();
    lit("contend_idle", 1'b0, 1'b0, 1'b1);

    // Tie bursts separated by idle gaps alternate winners
    for (int b = 0; b < 4; b++) begin
      int w;
      w = b % 2;
      req0 = 1'b1;
      req1 = 1'b1;
      edge1();
      lit("tie", w == 0, w == 1, w == 1);
      check("tie_mux", mout, (w == 1) ? 8'h3C : 8'hA5);
      req0 = 1'b0;
      req1 = 1'b0;
      edge1();
      lit("tie_gap", 1'b0, 1'b0, w == 1);
    end

    // Asynchronous reset mid-grant
    req1 = 1'b1;
    edge1();
    lit("pre_reset", 1'b0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    lit("async_reset", 1'b0, 1'b0, 1'b0);
    edge1();
    lit("reset_held", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    edge1();
    lit("post_reset_tie", 1'b1, 1'b0, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    edge1();
    lit("final_idle", 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
